payload_extract: RTL and testbench

Parametrised payload deframer for the DSSS 802.11b receiver, placed after the PLCP header decoder. It supports both 1 Mbps (DBPSK, 1 bit/symbol) and 2 Mbps (DQPSK, 2 bits/symbol) PSDUs. It converts the header LENGTH field (µs) into a bit count, assembles LSB-first bytes, tags the 4 FCS bytes, and checks CRC-32 serially on every bit. Length, rate and abort faults are reported with strobes rather than being silently ignored.

---
 rtl/payload_extract.sv | 142 ++++++++++++++
 tb/tb_payload_extract.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/payload_extract.sv
// 802.11b DSSS payload deframer: turns the PLCP LENGTH field into a bit count,
// assembles LSB-first bytes, flags the FCS bytes and checks CRC-32 bit-serially.
module payload_extract #(
   parameter int          LEN_W   = 16,
   parameter int          CNT_W   = 17,
   parameter logic [7:0]  RATE_1M = 8'h0A,
   parameter logic [7:0]  RATE_2M = 8'h14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       sym_bits,
   input  logic             sym_valid,
   input  logic             hdr_valid_strobe,
   input  logic [7:0]       pkt_rate,
   input  logic [LEN_W-1:0] pkt_len,
   input  logic             abort,
   output logic [7:0]       payload_data,
   output logic             payload_valid,
   output logic             payload_last,
   output logic             payload_is_fcs,
   output logic             crc_done,
   output logic             crc_ok,
   output logic             len_err,
   output logic             rate_err,
   output logic             pkt_abort,
   output logic             busy
);

   localparam logic [0:0]  IDLE    = 1'b0;
   localparam logic [0:0]  RUN     = 1'b1;
   localparam logic [31:0] POLY    = 32'hEDB8_8320;
   localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;

   logic [0:0]       state;
   logic             is_2m;
   logic [CNT_W-1:0] bits_left;
   logic [2:0]       bit_in_byte;
   logic [7:0]       shreg;
   logic [31:0]      crc;

   logic             hdr_is_1m;
   logic             hdr_is_2m;
   logic [CNT_W-1:0] hdr_bits;
   logic             hdr_len_bad;
   logic [31:0]      crc_a;
   logic [31:0]      crc_b;
   logic [31:0]      crc_next;
   logic [7:0]       shreg_next;
   logic [CNT_W-1:0] bits_left_next;
   logic [2:0]       bit_in_byte_next;
   logic             byte_done;
   logic             last_byte;

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
      crc_step = (c >> 1) ^ ((c[0] ^ b) ? POLY : 32'h0);
   endfunction

   // Header decode and the per-symbol datapath; at 2 Mbps two CRC steps are chained.
   always_comb begin
      hdr_is_1m        = (pkt_rate == RATE_1M);
      hdr_is_2m        = (pkt_rate == RATE_2M);
      hdr_bits         = hdr_is_2m ? (CNT_W'(pkt_len) << 1) : CNT_W'(pkt_len);
      hdr_len_bad      = (hdr_bits[2:0] != 3'd0) || (hdr_bits < CNT_W'(40));
      crc_a            = crc_step(crc, sym_bits[0]);
      crc_b            = crc_step(crc_a, sym_bits[1]);
      crc_next         = is_2m ? crc_b : crc_a;
      shreg_next       = is_2m ? {sym_bits[1], sym_bits[0], shreg[7:2]}
                               : {sym_bits[0], shreg[7:1]};
      bits_left_next   = bits_left - (is_2m ? CNT_W'(2) : CNT_W'(1));
      bit_in_byte_next = bit_in_byte + (is_2m ? 3'd2 : 3'd1);
      byte_done        = (bit_in_byte_next == 3'd0);
      last_byte        = (bits_left_next == '0);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         is_2m          <= 1'b0;
         bits_left      <= '0;
         bit_in_byte    <= 3'd0;
         shreg          <= 8'h00;
         crc            <= 32'hFFFF_FFFF;
         payload_data   <= 8'h00;
         payload_valid  <= 1'b0;
         payload_last   <= 1'b0;
         payload_is_fcs <= 1'b0;
         crc_done       <= 1'b0;
         crc_ok         <= 1'b0;
         len_err        <= 1'b0;
         rate_err       <= 1'b0;
         pkt_abort      <= 1'b0;
      end else begin
         payload_valid  <= 1'b0;
         payload_last   <= 1'b0;
         payload_is_fcs <= 1'b0;
         crc_done       <= 1'b0;
         len_err        <= 1'b0;
         rate_err       <= 1'b0;
         pkt_abort      <= 1'b0;
         // abort outranks a coincident header; a header mid-packet also kills the packet
         if (abort) begin
            if (state == RUN) pkt_abort <= 1'b1;
            state <= IDLE;
         end else if (hdr_valid_strobe) begin
            if (state == RUN) pkt_abort <= 1'b1;
            crc_ok <= 1'b0;
            if (!hdr_is_1m && !hdr_is_2m) begin
               rate_err <= 1'b1;
               state    <= IDLE;
            end else if (hdr_len_bad) begin
               len_err <= 1'b1;
               state   <= IDLE;
            end else begin
               state       <= RUN;
               is_2m       <= hdr_is_2m;
               bits_left   <= hdr_bits;
               bit_in_byte <= 3'd0;
               crc         <= 32'hFFFF_FFFF;
            end
         end else if (state == RUN && sym_valid) begin
            crc         <= crc_next;
            shreg       <= shreg_next;
            bits_left   <= bits_left_next;
            bit_in_byte <= bit_in_byte_next;
            if (byte_done) begin
               payload_valid  <= 1'b1;
               payload_data   <= shreg_next;
               payload_is_fcs <= (bits_left_next <= CNT_W'(24));
               if (last_byte) begin
                  payload_last <= 1'b1;
                  crc_done     <= 1'b1;
                  crc_ok       <= (crc_next == RESIDUE);
                  state        <= IDLE;
               end
            end
         end
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_payload_extract.sv
// Self-checking bench for payload_extract: header table, hand-written corner
// sequences and random packets checked against a byte-level CRC-32 model.
module tb_payload_extract;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  sym_bits;
   logic        sym_valid;
   logic        hdr_valid_strobe;
   logic [7:0]  pkt_rate;
   logic [15:0] pkt_len;
   logic        abort;
   logic [7:0]  payload_data;
   logic        payload_valid;
   logic        payload_last;
   logic        payload_is_fcs;
   logic        crc_done;
   logic        crc_ok;
   logic        len_err;
   logic        rate_err;
   logic        pkt_abort;
   logic        busy;

   payload_extract dut (
      .clk(clk), .reset(reset), .sym_bits(sym_bits), .sym_valid(sym_valid),
      .hdr_valid_strobe(hdr_valid_strobe), .pkt_rate(pkt_rate), .pkt_len(pkt_len),
      .abort(abort), .payload_data(payload_data), .payload_valid(payload_valid),
      .payload_last(payload_last), .payload_is_fcs(payload_is_fcs),
      .crc_done(crc_done), .crc_ok(crc_ok), .len_err(len_err), .rate_err(rate_err),
      .pkt_abort(pkt_abort), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  rate;
      logic [15:0] len;
      logic        exp_len_err;
      logic        exp_rate_err;
      logic        exp_busy;
   } hdr_vec_t;

   hdr_vec_t    hv[11];
   logic [7:0]  pkt[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      n_checks++;
      if (actual === expected) n_pass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      sym_valid        = 1'b0;
      sym_bits         = 2'b00;
      hdr_valid_strobe = 1'b0;
      abort            = 1'b0;
   endtask

   // Standard byte-wise software CRC-32 (reflected), returned already inverted as the FCS value.
   function automatic logic [31:0] ref_fcs(input int n);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'h0, pkt[i]};
         for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   function automatic logic exp_crc_ok();
      int n;
      n = pkt.size();
      return {pkt[n-1], pkt[n-2], pkt[n-3], pkt[n-4]} == ref_fcs(n - 4);
   endfunction

   task automatic send_header(input logic is2m, input int nbytes);
      hdr_valid_strobe = 1'b1;
      pkt_rate         = is2m ? 8'h14 : 8'h0A;
      pkt_len          = is2m ? 16'(nbytes * 4) : 16'(nbytes * 8);
      cycle();
      hdr_valid_strobe = 1'b0;
   endtask

   // Sends the first nbits bits of pkt and checks every byte strobe one cycle after its completing symbol.
   task automatic apply_stimulus(input logic is2m, input int nbits, input int max_gap);
      int per;
      int n;
      int k;
      int gap;
      per = is2m ? 2 : 1;
      n   = pkt.size();
      for (int b = 0; b < nbits; b += per) begin
         sym_bits[0] = pkt[b / 8][b % 8];
         sym_bits[1] = is2m ? pkt[(b + 1) / 8][(b + 1) % 8] : 1'b0;
         sym_valid   = 1'b1;
         cycle();
         sym_valid = 1'b0;
         sym_bits  = 2'b00;
         if ((b + per) % 8 == 0) begin
            k = (b + per) / 8 - 1;
            check_output("byte_valid", 32'(payload_valid), 32'd1);
            check_output("byte_data", 32'(payload_data), 32'(pkt[k]));
            check_output("is_fcs", 32'(payload_is_fcs), 32'(k >= n - 4));
            check_output("last", 32'(payload_last), 32'(k == n - 1));
            check_output("crc_done", 32'(crc_done), 32'(k == n - 1));
            if (k == n - 1) begin
               check_output("crc_ok", 32'(crc_ok), 32'(exp_crc_ok()));
               check_output("busy_end", 32'(busy), 32'd0);
            end
         end else begin
            check_output("no_byte", 32'(payload_valid), 32'd0);
         end
         gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         repeat (gap) begin
            cycle();
            check_output("gap_quiet", 32'(payload_valid), 32'd0);
         end
      end
   endtask

   task automatic load_ref_packet(input logic [7:0] first);
      pkt = '{first, 8'h8D, 8'hEF, 8'h02, 8'hD2};
   endtask

   initial begin
      logic [31:0] f;
      logic        is2m;
      int          ndata;
      int          pos;

      reset    = 1'b0;
      pkt_rate = 8'h00;
      pkt_len  = 16'h0000;
      idle_inputs();
      repeat (3) cycle();
      check_output("rst_valid", 32'(payload_valid), 32'd0);
      check_output("rst_data", 32'(payload_data), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_crc_ok", 32'(crc_ok), 32'd0);
      check_output("rst_strobes", {27'd0, payload_last, payload_is_fcs, crc_done, len_err,
                   rate_err | pkt_abort}, 32'd0);
      reset = 1'b1;
      cycle();

      hv[0]  = '{8'h0A, 16'd40,    1'b0, 1'b0, 1'b1};
      hv[1]  = '{8'h0A, 16'd33,    1'b1, 1'b0, 1'b0};
      hv[2]  = '{8'h14, 16'd16,    1'b1, 1'b0, 1'b0};
      hv[3]  = '{8'h37, 16'd40,    1'b0, 1'b1, 1'b0};
      hv[4]  = '{8'h0A, 16'd39,    1'b1, 1'b0, 1'b0};
      hv[5]  = '{8'h0A, 16'd32,    1'b1, 1'b0, 1'b0};
      hv[6]  = '{8'h14, 16'hFFFF,  1'b1, 1'b0, 1'b0};
      hv[7]  = '{8'h14, 16'd20,    1'b0, 1'b0, 1'b1};
      hv[8]  = '{8'h0A, 16'hFFF8,  1'b0, 1'b0, 1'b1};
      hv[9]  = '{8'h14, 16'h8000,  1'b0, 1'b0, 1'b1};
      hv[10] = '{8'h00, 16'd40,    1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 11; i++) begin
         hdr_valid_strobe = 1'b1;
         pkt_rate         = hv[i].rate;
         pkt_len          = hv[i].len;
         cycle();
         hdr_valid_strobe = 1'b0;
         check_output($sformatf("hdr%0d_len_err", i), 32'(len_err), 32'(hv[i].exp_len_err));
         check_output($sformatf("hdr%0d_rate_err", i), 32'(rate_err), 32'(hv[i].exp_rate_err));
         check_output($sformatf("hdr%0d_busy", i), 32'(busy), 32'(hv[i].exp_busy));
         check_output($sformatf("hdr%0d_valid", i), 32'(payload_valid), 32'd0);
         if (hv[i].exp_busy) begin
            abort = 1'b1;
            cycle();
            abort = 1'b0;
            check_output($sformatf("hdr%0d_abort", i), 32'(pkt_abort), 32'd1);
            check_output($sformatf("hdr%0d_idle", i), 32'(busy), 32'd0);
         end else begin
            cycle();
            check_output($sformatf("hdr%0d_pulse", i), 32'(len_err | rate_err), 32'd0);
            check_output($sformatf("hdr%0d_still_idle", i), 32'(busy), 32'd0);
         end
      end

      // Reference packet at 1 Mbps, then at 2 Mbps back-to-back.
      load_ref_packet(8'h00);
      send_header(1'b0, 5);
      check_output("t1_busy", 32'(busy), 32'd1);
      apply_stimulus(1'b0, 40, 2);
      cycle();
      check_output("t1_crc_ok_held", 32'(crc_ok), 32'd1);
      check_output("t1_crc_done_pulse", 32'(crc_done), 32'd0);

      sym_valid = 1'b1;
      repeat (9) begin
         sym_bits = 2'($urandom_range(0, 3));
         cycle();
         check_output("idle_sym_ignored", 32'(payload_valid | busy), 32'd0);
      end
      idle_inputs();

      send_header(1'b1, 5);
      apply_stimulus(1'b1, 40, 0);

      reset = 1'b0;
      cycle();
      check_output("rst_clears_crc_ok", 32'(crc_ok), 32'd0);
      reset = 1'b1;
      cycle();

      load_ref_packet(8'h01);
      send_header(1'b0, 5);
      apply_stimulus(1'b0, 40, 1);

      // Abort after 12 bits, then a clean packet.
      load_ref_packet(8'h00);
      send_header(1'b0, 5);
      apply_stimulus(1'b0, 12, 1);
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      check_output("ab_pulse", 32'(pkt_abort), 32'd1);
      check_output("ab_busy", 32'(busy), 32'd0);
      check_output("ab_no_byte", 32'(payload_valid), 32'd0);
      check_output("ab_no_crc_done", 32'(crc_done), 32'd0);
      cycle();
      check_output("ab_pulse_once", 32'(pkt_abort), 32'd0);
      send_header(1'b0, 5);
      apply_stimulus(1'b0, 40, 0);

      // Abort on the very symbol that completes a byte suppresses that byte.
      send_header(1'b0, 5);
      apply_stimulus(1'b0, 7, 0);
      sym_bits  = {1'b0, pkt[0][7]};
      sym_valid = 1'b1;
      abort     = 1'b1;
      cycle();
      idle_inputs();
      check_output("abyte_suppressed", 32'(payload_valid), 32'd0);
      check_output("abyte_abort", 32'(pkt_abort), 32'd1);

      // New header in RUN after 20 bits, with a coincident symbol that must be dropped.
      send_header(1'b0, 5);
      apply_stimulus(1'b0, 20, 1);
      hdr_valid_strobe = 1'b1;
      pkt_rate         = 8'h14;
      pkt_len          = 16'd20;
      sym_valid        = 1'b1;
      sym_bits         = 2'b11;
      cycle();
      idle_inputs();
      check_output("rehdr_abort", 32'(pkt_abort), 32'd1);
      check_output("rehdr_busy", 32'(busy), 32'd1);
      check_output("rehdr_errs", 32'(len_err | rate_err), 32'd0);
      apply_stimulus(1'b1, 40, 1);

      // abort and header together: abort wins.
      send_header(1'b0, 5);
      apply_stimulus(1'b0, 20, 0);
      abort            = 1'b1;
      hdr_valid_strobe = 1'b1;
      pkt_rate         = 8'h0A;
      pkt_len          = 16'd40;
      cycle();
      idle_inputs();
      check_output("abhdr_abort", 32'(pkt_abort), 32'd1);
      check_output("abhdr_busy", 32'(busy), 32'd0);
      check_output("abhdr_errs", 32'(len_err | rate_err), 32'd0);

      // Bad-rate header mid-packet: both abort and rate_err.
      send_header(1'b1, 5);
      apply_stimulus(1'b1, 10, 0);
      hdr_valid_strobe = 1'b1;
      pkt_rate         = 8'h37;
      cycle();
      idle_inputs();
      check_output("badhdr_abort", 32'(pkt_abort), 32'd1);
      check_output("badhdr_rate_err", 32'(rate_err), 32'd1);
      check_output("badhdr_busy", 32'(busy), 32'd0);

      // Reset mid-packet.
      send_header(1'b0, 5);
      apply_stimulus(1'b0, 12, 0);
      reset     = 1'b0;
      sym_valid = 1'b1;
      cycle();
      idle_inputs();
      check_output("mrst_busy", 32'(busy), 32'd0);
      check_output("mrst_data", 32'(payload_data), 32'd0);
      check_output("mrst_strobes", {28'd0, payload_valid, pkt_abort, crc_done, payload_last},
                   32'd0);
      reset = 1'b1;
      cycle();
      send_header(1'b1, 5);
      apply_stimulus(1'b1, 40, 1);

      // Random packets; a quarter carry one corrupted byte.
      for (int p = 0; p < 14; p++) begin
         is2m  = 1'($urandom_range(0, 1));
         ndata = int'($urandom_range(1, 10));
         pkt.delete();
         for (int i = 0; i < ndata; i++) pkt.push_back(8'($urandom_range(0, 255)));
         f = ref_fcs(ndata);
         pkt.push_back(f[7:0]);
         pkt.push_back(f[15:8]);
         pkt.push_back(f[23:16]);
         pkt.push_back(f[31:24]);
         if ($urandom_range(0, 3) == 0) begin
            pos      = int'($urandom_range(0, ndata + 3));
            pkt[pos] = pkt[pos] ^ 8'(1 << $urandom_range(0, 7));
         end
         send_header(is2m, ndata + 4);
         check_output("rnd_busy", 32'(busy), 32'd1);
         apply_stimulus(is2m, (ndata + 4) * 8, 3);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
